// File: rtl/note_lane_shifter_pkg.sv
// Shared constants for the rhythm-game note lanes: default geometry, lane indices
// and the judgement encoding that the score block also uses.
package note_lane_pkg;

    localparam int DEF_WIDTH = 100;
    localparam int DEF_LANES = 2;
    localparam int DEF_DIV_W = 20;

    localparam int LANE_CENTRE = 0;
    localparam int LANE_RIM    = 1;

    typedef enum logic [1:0] {
        JUDGE_NONE = 2'd0,
        JUDGE_OK   = 2'd1,
        JUDGE_BAD  = 2'd2,
        JUDGE_MISS = 2'd3
    } judge_e;

endpackage

// File: rtl/note_lane_shifter_if.sv
// Control/status bundle between the playfield controller and the note lane shifter.
interface note_lane_shifter_if
    import note_lane_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int DIV_W = DEF_DIV_W
);
    logic                     load;
    logic [LANES*WIDTH-1:0]   load_val;
    logic [LANES-1:0]         serial_in;
    logic                     enable;
    logic [DIV_W-1:0]         period;
    logic [LANES-1:0]         hit;
    logic [LANES*WIDTH-1:0]   lane_out;
    logic                     step;
    logic [LANES-1:0]         at_target;
    logic [LANES-1:0]         hit_ok;
    logic [LANES-1:0]         hit_bad;
    logic [LANES-1:0]         miss;

    modport master (
        output load, load_val, serial_in, enable, period, hit,
        input  lane_out, step, at_target, hit_ok, hit_bad, miss
    );

    modport slave (
        input  load, load_val, serial_in, enable, period, hit,
        output lane_out, step, at_target, hit_ok, hit_bad, miss
    );
endinterface

// File: rtl/note_lane_shifter_cell.sv
// One note lane: shift toward bit 0, parallel load, and hit/miss judgement at the target.
module note_lane_cell
    import note_lane_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             serial_in,
    input  logic             step,
    input  logic             hit,
    output logic [WIDTH-1:0] lane,
    output logic             hit_ok,
    output logic             hit_bad,
    output logic             miss
);
    judge_e judge;

    always_comb begin
        judge = JUDGE_NONE;
        if (hit)
            judge = lane[0] ? JUDGE_OK : JUDGE_BAD;
        else if (step && lane[0])
            judge = JUDGE_MISS;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane    <= '0;
            hit_ok  <= 1'b0;
            hit_bad <= 1'b0;
            miss    <= 1'b0;
        end else if (load) begin
            lane    <= load_val;
            hit_ok  <= 1'b0;
            hit_bad <= 1'b0;
            miss    <= 1'b0;
        end else begin
            hit_ok  <= (judge == JUDGE_OK);
            hit_bad <= (judge == JUDGE_BAD);
            miss    <= (judge == JUDGE_MISS);
            // A consumed note that is also shifting out simply leaves; only clear it in place when idle.
            if (step)
                lane <= {serial_in, lane[WIDTH-1:1]};
            else if (judge == JUDGE_OK)
                lane[0] <= 1'b0;
        end
    end
endmodule

// File: rtl/note_lane_shifter.sv
// Multi-lane note shift register with a shared scroll-rate prescaler.
module note_lane_shifter
    import note_lane_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic              clock,
    input  logic              reset,
    note_lane_shifter_if.slave bus
);
    logic [DIV_W-1:0]       cnt;
    logic                   step_now;
    logic                   step_q;
    logic [LANES*WIDTH-1:0] lane_all;
    logic [LANES-1:0]       ok_all;
    logic [LANES-1:0]       bad_all;
    logic [LANES-1:0]       miss_all;
    logic [LANES-1:0]       tgt_all;

    // >= rather than == so shrinking period below cnt fires immediately instead of wrapping.
    assign step_now = bus.enable && !bus.load && (cnt >= bus.period);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            step_q <= 1'b0;
        end else if (bus.load) begin
            cnt    <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= step_now;
            if (bus.enable)
                cnt <= step_now ? '0 : cnt + DIV_W'(1);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        note_lane_cell #(.WIDTH(WIDTH)) u_cell (
            .clock     (clock),
            .reset     (reset),
            .load      (bus.load),
            .load_val  (bus.load_val[l*WIDTH +: WIDTH]),
            .serial_in (bus.serial_in[l]),
            .step      (step_now),
            .hit       (bus.hit[l]),
            .lane      (lane_all[l*WIDTH +: WIDTH]),
            .hit_ok    (ok_all[l]),
            .hit_bad   (bad_all[l]),
            .miss      (miss_all[l])
        );
        assign tgt_all[l] = lane_all[l*WIDTH];
    end

    assign bus.lane_out  = lane_all;
    assign bus.step      = step_q;
    assign bus.at_target = tgt_all;
    assign bus.hit_ok    = ok_all;
    assign bus.hit_bad   = bad_all;
    assign bus.miss      = miss_all;
endmodule
